// File: rtl/gold_miner_pkg.sv
// Shared gold-miner types: round-sequencer states, timer reload value, per-level target.
// Pure declarations; no latency and no flow control.
package gold_miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_JUDGE,
        ST_CLEAR,
        ST_LOSE,
        ST_WIN
    } state_e;

    localparam int TIMER_RELOAD_SECS = 45;

    function automatic int target_of(input int lvl, input int base, input int step);
        return base + lvl * step;
    endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two BCD digits to 6-bit binary, one registered stage; present only when ROUND_TIME_BONUS_EN is defined.
// Free-running: samples every cycle, no handshake.
`ifdef ROUND_TIME_BONUS_EN
module bcd2_to_bin (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] tenth_i,
    input  logic [3:0] oneth_i,
    output logic [5:0] bin_o
);

    logic [6:0] sum_w;
    logic [5:0] bin_q;
    logic       unused_msb;

    // tens * 10 computed as tens*8 + tens*2
    assign sum_w      = {tenth_i, 3'b000} + {2'b00, tenth_i, 1'b0} + {3'b000, oneth_i};
    assign unused_msb = sum_w[6];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bin_q <= '0;
        end else begin
            bin_q <= sum_w[5:0];
        end
    end

    assign bin_o = bin_q;

endmodule
`endif

// File: rtl/round_controller.sv
// Gold-miner round sequencer: timer enable, score accumulation, per-level judging; all outputs registered, 1-cycle latency.
// No backpressure: single-cycle pulses are consumed when seen. Time bonus enabled by ROUND_TIME_BONUS_EN.
module round_controller
    import gold_miner_pkg::*;
#(
    parameter int SCORE_W     = 12,
    parameter int LEVELS      = 4,
    parameter int TARGET_BASE = 100,
    parameter int TARGET_STEP = 50,
    localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               item_valid,
    input  logic [7:0]         item_value,
    input  logic               time_done,
    input  logic [3:0]         tenth,
    input  logic [3:0]         oneth,
    output logic               timer_enable,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round_score,
    output logic [LVL_W-1:0]   level,
    output logic               round_won,
    output logic               game_over,
    output logic               game_won
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [LVL_W-1:0]   LAST_LEVEL = LVL_W'(LEVELS - 1);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, round_q, round_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               te_q, won_q, over_q, gwon_q;
    logic [31:0]        target_w;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [7:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {{(SCORE_W-7){1'b0}}, b};
        return s[SCORE_W] ? SCORE_MAX : s[SCORE_W-1:0];
    endfunction

    assign target_w = 32'(target_of(32'(level_q), TARGET_BASE, TARGET_STEP));

`ifdef ROUND_TIME_BONUS_EN
    logic [5:0] digits_bin;
    logic [5:0] bonus_w;
    logic       bonus_zero_q;

    bcd2_to_bin u_bcd2_to_bin (
        .clk     (clk),
        .resetn  (resetn),
        .tenth_i (tenth),
        .oneth_i (oneth),
        .bin_o   (digits_bin)
    );

    // JUDGE always follows the exit cycle, so the registered conversion holds exactly the exit-cycle digits
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bonus_zero_q <= 1'b1;
        end else if (state_q == ST_PLAY && state_d == ST_JUDGE) begin
            bonus_zero_q <= time_done;
        end
    end

    assign bonus_w = bonus_zero_q ? 6'd0 :
                     (digits_bin > 6'(TIMER_RELOAD_SECS)) ? 6'(TIMER_RELOAD_SECS) : digits_bin;
`else
    logic unused_digits;
    assign unused_digits = ^{tenth, oneth};
`endif

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        round_d = round_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                score_d = '0;
                round_d = '0;
                level_d = '0;
                if (start) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (item_valid) begin
                    round_d = sat_add(round_q, item_value);
                    score_d = sat_add(score_q, item_value);
                end
                if (time_done || (32'(round_d) >= target_w)) state_d = ST_JUDGE;
            end
            ST_JUDGE: begin
                if (32'(round_q) >= target_w) begin
                    state_d = (level_q == LAST_LEVEL) ? ST_WIN : ST_CLEAR;
`ifdef ROUND_TIME_BONUS_EN
                    score_d = sat_add(score_q, {2'b00, bonus_w});
`endif
                end else begin
                    state_d = ST_LOSE;
                end
            end
            ST_CLEAR: begin
                if (start) begin
                    level_d = level_q + LVL_W'(1);
                    round_d = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_LOSE, ST_WIN: begin
                if (start) begin
                    score_d = '0;
                    round_d = '0;
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            round_q <= '0;
            level_q <= '0;
            te_q    <= 1'b0;
            won_q   <= 1'b0;
            over_q  <= 1'b0;
            gwon_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            round_q <= round_d;
            level_q <= level_d;
            te_q    <= (state_d == ST_PLAY);
            won_q   <= (state_d == ST_CLEAR);
            over_q  <= (state_d == ST_LOSE);
            gwon_q  <= (state_d == ST_WIN);
        end
    end

    assign timer_enable = te_q;
    assign score        = score_q;
    assign round_score  = round_q;
    assign level        = level_q;
    assign round_won    = won_q;
    assign game_over    = over_q;
    assign game_won     = gwon_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: scripted rounds with a queue of expected outputs, plus a saturation instance.
module tb_round_controller;

    logic        clk = 1'b0;
    logic        resetn, start, item_valid, time_done;
    logic [7:0]  item_value;
    logic [3:0]  tenth, oneth;

    logic        timer_enable, round_won, game_over, game_won;
    logic [11:0] score, round_score;
    logic [1:0]  level;

    logic        s_timer_enable, s_round_won, s_game_over, s_game_won;
    logic [11:0] s_score, s_round_score;
    logic [1:0]  s_level;

    always #5 clk = ~clk;

`ifdef ROUND_TIME_BONUS_EN
    localparam int BONUS_27 = 27;
`else
    localparam int BONUS_27 = 0;
`endif

    round_controller dut (
        .clk(clk), .resetn(resetn), .start(start), .item_valid(item_valid),
        .item_value(item_value), .time_done(time_done), .tenth(tenth), .oneth(oneth),
        .timer_enable(timer_enable), .score(score), .round_score(round_score), .level(level),
        .round_won(round_won), .game_over(game_over), .game_won(game_won)
    );

    // Unreachable target keeps this instance in PLAY so the score can be driven to saturation.
    round_controller #(.TARGET_BASE(5000)) dut_sat (
        .clk(clk), .resetn(resetn), .start(start), .item_valid(item_valid),
        .item_value(item_value), .time_done(time_done), .tenth(tenth), .oneth(oneth),
        .timer_enable(s_timer_enable), .score(s_score), .round_score(s_round_score), .level(s_level),
        .round_won(s_round_won), .game_over(s_game_over), .game_won(s_game_won)
    );

    typedef struct {
        string tag;
        int    te, sc, rs, lv, rw, go, gw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic drive(input int s, input int iv, input int v, input int td);
        start      = 1'(s);
        item_valid = 1'(iv);
        item_value = 8'(v);
        time_done  = 1'(td);
    endtask

    // Drive one cycle of stimulus with no expectation attached.
    task automatic nop(input int s, input int iv, input int v, input int td);
        drive(s, iv, v, td);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
    endtask

    // Drive one cycle, queue its expected post-edge outputs, then score whatever is queued.
    task automatic step(input string tag, input int s, input int iv, input int v, input int td,
                        input int te, input int sc, input int rs, input int lv,
                        input int rw, input int go, input int gw);
        exp_t e;
        drive(s, iv, v, td);
        sb.push_back('{tag, te, sc, rs, lv, rw, go, gw});
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".timer_enable"}, 32'(timer_enable), 32'(e.te));
            chk({e.tag, ".score"},        32'(score),        32'(e.sc));
            chk({e.tag, ".round_score"},  32'(round_score),  32'(e.rs));
            chk({e.tag, ".level"},        32'(level),        32'(e.lv));
            chk({e.tag, ".round_won"},    32'(round_won),    32'(e.rw));
            chk({e.tag, ".game_over"},    32'(game_over),    32'(e.go));
            chk({e.tag, ".game_won"},     32'(game_won),     32'(e.gw));
        end
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        tenth  = 4'd0;
        oneth  = 4'd0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Three items of 40 clear level 0, then play through to the win.
        do_reset("rst0");
        step("t1_start",  1, 0, 0,   0, 1, 0,   0,   0, 0, 0, 0);
        step("t1_pstart", 1, 0, 0,   0, 1, 0,   0,   0, 0, 0, 0);
        step("t1_i1",     0, 1, 40,  0, 1, 40,  40,  0, 0, 0, 0);
        step("t1_i2",     0, 1, 40,  0, 1, 80,  80,  0, 0, 0, 0);
        step("t1_judge",  0, 1, 40,  0, 0, 120, 120, 0, 0, 0, 0);
        step("t1_clear",  0, 0, 0,   0, 0, 120, 120, 0, 1, 0, 0);
        step("t1_hold",   0, 0, 0,   0, 0, 120, 120, 0, 1, 0, 0);
        step("l1_start",  1, 0, 0,   0, 1, 120, 0,   1, 0, 0, 0);
        step("l1_judge",  0, 1, 255, 0, 0, 375, 255, 1, 0, 0, 0);
        step("l1_clear",  0, 0, 0,   0, 0, 375, 255, 1, 1, 0, 0);
        step("l2_start",  1, 0, 0,   0, 1, 375, 0,   2, 0, 0, 0);
        step("l2_judge",  0, 1, 255, 0, 0, 630, 255, 2, 0, 0, 0);
        step("l2_clear",  0, 0, 0,   0, 0, 630, 255, 2, 1, 0, 0);
        step("l3_start",  1, 0, 0,   0, 1, 630, 0,   3, 0, 0, 0);
        step("l3_judge",  0, 1, 255, 0, 0, 885, 255, 3, 0, 0, 0);
        step("win",       0, 0, 0,   0, 0, 885, 255, 3, 0, 0, 1);
        step("win_hold",  0, 0, 0,   0, 0, 885, 255, 3, 0, 0, 1);
        step("win_start", 1, 0, 0,   0, 0, 0,   0,   0, 0, 0, 0);

        // Timer expiry short of the target loses.
        do_reset("rst1");
        step("t2_start",  1, 0, 0,  0, 1, 0,  0,  0, 0, 0, 0);
        step("t2_item",   0, 1, 30, 0, 1, 30, 30, 0, 0, 0, 0);
        step("t2_judge",  0, 0, 0,  1, 0, 30, 30, 0, 0, 0, 0);
        step("t2_lose",   0, 0, 0,  0, 0, 30, 30, 0, 0, 1, 0);
        step("t2_idle",   1, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0);

        // Item coincident with expiry counts; expiry also suppresses any bonus.
        tenth = 4'd2;
        oneth = 4'd7;
        do_reset("rst2");
        step("t3_start",  1, 0, 0,  0, 1, 0,   0,   0, 0, 0, 0);
        step("t3_item",   0, 1, 30, 0, 1, 30,  30,  0, 0, 0, 0);
        step("t3_judge",  0, 1, 70, 1, 0, 100, 100, 0, 0, 0, 0);
        step("t3_clear",  0, 0, 0,  0, 0, 100, 100, 0, 1, 0, 0);

        // Target hit with 27 s left on the clock.
        do_reset("rst3");
        step("t4_start",  1, 0, 0,   0, 1, 0,   0,   0, 0, 0, 0);
        step("t4_judge",  0, 1, 100, 0, 0, 100, 100, 0, 0, 0, 0);
        step("t4_clear",  0, 0, 0,   0, 0, 100 + BONUS_27, 100, 0, 1, 0, 0);
        tenth = 4'd0;
        oneth = 4'd0;

        // Reset mid-round returns everything to zero on the next edge.
        do_reset("rst4");
        step("t5_start",  1, 0, 0,  0, 1, 0,  0,  0, 0, 0, 0);
        step("t5_item",   0, 1, 80, 0, 1, 80, 80, 0, 0, 0, 0);
        do_reset("t5_midrst");
        step("t5_again",  1, 0, 0,  0, 1, 0,  0,  0, 0, 0, 0);

        // Saturation on the high-target instance.
        do_reset("rst5");
        nop(1, 0, 0, 0);
        chk("sat_te_start", 32'(s_timer_enable), 32'd1);
        for (int i = 1; i <= 18; i++) begin
            nop(0, 1, 255, 0);
            chk($sformatf("sat_score_%0d", i), 32'(s_score),       (255 * i > 4095) ? 32'd4095 : 32'(255 * i));
            chk($sformatf("sat_round_%0d", i), 32'(s_round_score), (255 * i > 4095) ? 32'd4095 : 32'(255 * i));
        end
        chk("sat_te_end", 32'(s_timer_enable), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
